// File: rtl/pseudo_pll_pkg.sv
`timescale 1ms/1us
// pseudo_pll_pkg: shared constants and divisor helpers for the pseudo_pll slice.
// The optional lock indicator is enabled by the PSEUDO_PLL_LOCK_EN macro.
package pseudo_pll_pkg;

   localparam int unsigned DIV_MIN       = 2;
   localparam int unsigned DIV_WIDTH_DEF = 8;

   typedef struct packed {
      logic [31:0] div;
      logic [31:0] high;
   } div_cfg_t;

   // Divisors below DIV_MIN cannot produce both a high and a low phase.
   function automatic logic [31:0] sanitize_div(input logic [31:0] raw);
      return (raw < DIV_MIN) ? DIV_MIN : raw;
   endfunction

   function automatic logic [31:0] high_time(input logic [31:0] n);
      return n - (n >> 1);
   endfunction

   function automatic div_cfg_t div_cfg(input logic [31:0] raw);
      div_cfg_t cfg;
      cfg.div  = sanitize_div(raw);
      cfg.high = high_time(cfg.div);
      return cfg;
   endfunction

endpackage

// File: rtl/pseudo_pll_div_cnt.sv
`timescale 1ms/1us
// pseudo_pll_div_cnt: phase counter and active divisor; div_i is taken only on the wrap edge.
// Shared by both PSEUDO_PLL_LOCK_EN builds unchanged.
module pseudo_pll_div_cnt
   import pseudo_pll_pkg::*;
#(
   parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic [DIV_WIDTH-1:0] cnt_o,
   output logic [DIV_WIDTH-1:0] div_act_o,
   output logic [DIV_WIDTH-1:0] div_next_o,
   output logic                 wrap_o
);

   localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(sanitize_div(32'(DEFAULT_DIV)));

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
   logic [DIV_WIDTH-1:0] div_san;
   logic                 wrap;

   assign div_san = DIV_WIDTH'(sanitize_div(32'(div_i)));
   assign wrap    = (cnt_q == (div_act_q - DIV_WIDTH'(1)));

   always_comb begin
      cnt_d     = cnt_q;
      div_act_d = div_act_q;
      if (!en_i) begin
         cnt_d     = '0;
         div_act_d = div_san;
      end else if (wrap) begin
         cnt_d     = '0;
         div_act_d = div_san;
      end else begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         div_act_q <= RST_DIV;
      end else begin
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign div_act_o  = div_act_q;
   assign div_next_o = div_san;
   assign wrap_o     = wrap;

endmodule

// File: rtl/pseudo_pll.sv
`timescale 1ms/1us
// pseudo_pll: integer clock divider with a registered, glitch-free clk_out.
// Define PSEUDO_PLL_LOCK_EN to add the locked output and its flop.
module pseudo_pll
   import pseudo_pll_pkg::*;
#(
   parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div_in,
`ifdef PSEUDO_PLL_LOCK_EN
   output logic                 locked,
`endif
   output logic                 clk_out
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] div_act;
   logic [DIV_WIDTH-1:0] div_next;
   logic [DIV_WIDTH-1:0] high;
   logic                 wrap;
   logic                 clk_out_q, clk_out_d;

   pseudo_pll_div_cnt #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div_cnt (
      .clk_i      (clk_in),
      .rst_ni     (rst_n),
      .en_i       (en),
      .div_i      (div_in),
      .cnt_o      (cnt),
      .div_act_o  (div_act),
      .div_next_o (div_next),
      .wrap_o     (wrap)
   );

   assign high = DIV_WIDTH'(high_time(32'(div_act)));

   always_comb begin
      clk_out_d = 1'b0;
      if (en) begin
         clk_out_d = (cnt < high);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         clk_out_q <= 1'b0;
      end else begin
         clk_out_q <= clk_out_d;
      end
   end

   assign clk_out = clk_out_q;

`ifdef PSEUDO_PLL_LOCK_EN
   logic locked_q, locked_d;

   // Lock is re-judged only at period boundaries: held if the next divisor matches.
   always_comb begin
      locked_d = locked_q;
      if (!en) begin
         locked_d = 1'b0;
      end else if (wrap) begin
         locked_d = (div_next == div_act);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= locked_d;
      end
   end

   assign locked = locked_q;
`else
   logic unused_div_next;
   assign unused_div_next = ^div_next;
`endif

endmodule

// File: tb/tb_pseudo_pll.sv
`timescale 1ms/1us
// tb_pseudo_pll: period-level reference model feeding a scoreboard queue; a monitor checks each edge.
// locked is checked only when PSEUDO_PLL_LOCK_EN is defined.
module tb_pseudo_pll;

   localparam int unsigned W       = 8;
   localparam int unsigned DEF_DIV = 2;

   logic         clk_in;
   logic         rst_n;
   logic         en;
   logic [W-1:0] div_in;
   logic         clk_out;
`ifdef PSEUDO_PLL_LOCK_EN
   logic         locked;
`endif

   typedef struct {
      bit          clk;
      bit          lock;
      int unsigned edge_no;
   } exp_t;

   exp_t         exp_q[$];
   int unsigned  checks   = 0;
   int unsigned  errors   = 0;
   int unsigned  edge_cnt = 0;

   int unsigned  cur_n;
   bit           lock_m;
   logic [W-1:0] cur_div;

   pseudo_pll #(
      .DIV_WIDTH   (W),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en),
      .div_in  (div_in),
`ifdef PSEUDO_PLL_LOCK_EN
      .locked  (locked),
`endif
      .clk_out (clk_out)
   );

   initial begin : clock_gen
      clk_in = 1'b0;
      forever #0.5 clk_in = ~clk_in;
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: got no finish by %0t, want finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic int unsigned san(input int unsigned v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic step(input logic r, input logic e, input logic [W-1:0] d,
                       input bit ec, input bit el);
      exp_t x;
      @(negedge clk_in);
      rst_n  = r;
      en     = e;
      div_in = d;
      edge_cnt++;
      x.clk     = ec;
      x.lock    = el;
      x.edge_no = edge_cnt;
      exp_q.push_back(x);
   endtask

   // Reset (en random, reset wins) or disable for len edges; outputs forced low.
   task automatic do_abort(input int unsigned len, input bit use_rst);
      for (int unsigned i = 0; i < len; i++) begin
         if (use_rst) step(1'b0, 1'($urandom_range(1)), cur_div, 1'b0, 1'b0);
         else         step(1'b1, 1'b0, cur_div, 1'b0, 1'b0);
      end
      cur_n  = use_rst ? san(DEF_DIV) : san(32'(cur_div));
      lock_m = 1'b0;
   endtask

   // One output period of cur_n edges: high for the first n - n/2 edges, then low.
   task automatic do_period(input logic [W-1:0] d_new, input int unsigned chg_at,
                            input int unsigned abort_at, input bit abort_rst,
                            input int unsigned abort_len);
      int unsigned n = cur_n;
      int unsigned h = n - n / 2;
      for (int unsigned j = 1; j <= n; j++) begin
         if (j == chg_at) cur_div = d_new;
         if (j == abort_at) begin
            do_abort(abort_len, abort_rst);
            return;
         end
         if (j < n) step(1'b1, 1'b1, cur_div, j <= h, lock_m);
         else       step(1'b1, 1'b1, cur_div, j <= h, san(32'(cur_div)) == n);
      end
      lock_m = (san(32'(cur_div)) == n);
      cur_n  = san(32'(cur_div));
   endtask

   always @(posedge clk_in) begin : monitor
      exp_t x;
      #0.25;
      if (exp_q.size() != 0) begin
         x = exp_q.pop_front();
         checks++;
         if (clk_out !== x.clk) begin
            errors++;
            $display("FAIL clk_out edge %0d: got %b want %b", x.edge_no, clk_out, x.clk);
         end
`ifdef PSEUDO_PLL_LOCK_EN
         checks++;
         if (locked !== x.lock) begin
            errors++;
            $display("FAIL locked edge %0d: got %b want %b", x.edge_no, locked, x.lock);
         end
`endif
      end
   end

   initial begin : stim
      logic [W-1:0] d;
      int unsigned  chg;
      rst_n   = 1'b0;
      en      = 1'b0;
      cur_div = W'(DEF_DIV);
      div_in  = cur_div;
      cur_n   = san(DEF_DIV);
      lock_m  = 1'b0;

      // divide by 2 straight out of a 3-cycle reset
      do_abort(3, 1'b1);
      repeat (4) do_period(W'(2), 0, 0, 1'b0, 0);

      // divide by 5 loaded while disabled
      cur_div = W'(5);
      do_abort(1, 1'b0);
      repeat (3) do_period(W'(5), 0, 0, 1'b0, 0);

      // 4 -> 6 change mid-period
      cur_div = W'(4);
      do_abort(2, 1'b0);
      do_period(W'(4), 0, 0, 1'b0, 0);
      do_period(W'(6), 2, 0, 1'b0, 0);
      repeat (2) do_period(W'(6), 0, 0, 1'b0, 0);

      // 0 and 1 behave as 2
      cur_div = W'(0);
      do_abort(1, 1'b0);
      repeat (3) do_period(W'(0), 0, 0, 1'b0, 0);
      do_period(W'(1), 1, 0, 1'b0, 0);
      repeat (2) do_period(W'(1), 0, 0, 1'b0, 0);

      // reset mid-high-phase at divide by 8
      cur_div = W'(8);
      do_abort(1, 1'b0);
      do_period(W'(8), 0, 0, 1'b0, 0);
      do_period(W'(8), 0, 3, 1'b1, 1);
      repeat (3) do_period(W'(8), 0, 0, 1'b0, 0);

      // maximum divisor 2^W-1
      cur_div = W'(255);
      do_abort(1, 1'b0);
      do_period(W'(255), 0, 0, 1'b0, 0);
      do_period(W'(3), 200, 0, 1'b0, 0);

      repeat (300) begin
         if ($urandom_range(39) == 0) d = W'($urandom_range(250, 255));
         else                         d = W'($urandom_range(0, 12));
         chg = ($urandom_range(2) == 0) ? 0 : $urandom_range(1, cur_n);
         if ($urandom_range(11) == 0)
            do_period(d, chg, $urandom_range(1, cur_n), 1'($urandom_range(1)),
                      $urandom_range(1, 3));
         else
            do_period(d, chg, 0, 1'b0, 0);
      end

      repeat (3) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pseudo_pll.md
PSEUDO_PLL -- requirements
Module: pseudo_pll

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of the divisor input and internal counter.
REQ-002 Parameter DEFAULT_DIV, default 2: divisor loaded at reset.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  run enable; low freezes the generator in its idle state.
REQ-006 div_in  input  DIV_WIDTH  requested divisor N, the output period in clk_in cycles.
REQ-007 clk_out  output  1  divided clock, driven directly from a flop, glitch-free.
REQ-008 locked  output  1  high while clk_out runs at the active divisor; present only under PSEUDO_PLL_LOCK_EN.

Function
REQ-009 Internal state: active divisor div_act, phase counter cnt (0..div_act-1), clk_out flop, locked flop.
REQ-010 Effective divisor is max(value, 2); a value of 0 or 1 on div_in or in DEFAULT_DIV SHALL be treated as 2.
REQ-011 High time H = div_act - floor(div_act/2) cycles; low time = floor(div_act/2) cycles (odd N: high one cycle longer).
REQ-012 Each enabled edge: clk_out <= (cnt < H); cnt <= (cnt == div_act-1) ? 0 : cnt+1, both computed from pre-edge values.
REQ-013 First enabled edge after reset or enable sets clk_out high; the period is exactly div_act edges thereafter.
REQ-014 div_in is sampled only on the wrap edge (cnt == div_act-1) and becomes div_act for the next period; changes mid-period SHALL NOT alter the current period.
REQ-015 locked rises on the first wrap edge after reset or enable.
REQ-016 locked clears on any wrap edge that loads a div_act different from the current one, and rises again on the following wrap.
REQ-017 en low on an edge: cnt <= 0, clk_out <= 0, locked <= 0, div_act <= sanitised div_in. Re-enable behaves as post-reset (REQ-013).
REQ-018 Simultaneous rst_n low and en high: reset wins.
REQ-019 Counter arithmetic SHALL be DIV_WIDTH bits with no overflow, because cnt < div_act <= 2^DIV_WIDTH-1.

Reset
REQ-020 On an edge with rst_n low: cnt = 0, clk_out = 0, locked = 0, div_act = sanitised DEFAULT_DIV.
REQ-021 Reset asserted mid-period SHALL abort the period at that edge, with no partial-pulse extension.

Configuration
REQ-022 Macro PSEUDO_PLL_LOCK_EN defined: the locked port and its flop exist per REQ-015/016.
REQ-023 Macro PSEUDO_PLL_LOCK_EN undefined: no locked port and no lock logic; clk_out behaviour is identical.

Structure
REQ-024 Package pseudo_pll_pkg holds DIV_MIN = 2, the default DIV_WIDTH, and a function computing the sanitised divisor and H.
REQ-025 One sub-module, pseudo_pll_div_cnt, holds cnt, div_act and the wrap flag; the top adds the clk_out and locked flops.

Verification
REQ-026 Bench clock source clock_gen drives clk_in free-running, period 1 time unit (1 ms timescale); each run lasts at least 30 ms; VCD dump path is taken from plusarg VCD_PATH, default output.vcd.
REQ-027 Reset 3 cycles, en=1, div_in=2 -> clk_out 1,0,1,0... from the first edge after reset; locked=1 after edge 2.
REQ-028 div_in=5 held -> clk_out high 3 edges, low 2 edges, period 5; locked rises at the first wrap.
REQ-029 div_in changes 4->6 mid-period -> current period stays 4; next period is 6 (high 3, low 3); locked is 0 for that period, 1 after it.
REQ-030 div_in=0 and div_in=1 -> clk_out identical to the div_in=2 case.
REQ-031 rst_n low for one edge mid-high-phase at div 8 -> next edge clk_out=0, locked=0; restart per REQ-013 with DEFAULT_DIV.
